// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: refresh scan, ghost guard,
// leading-zero blanking and frame-synchronous (tear-free) digit loading.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_in,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  // The scan position (idx, cnt) is the whole state; phase is derived from it.
  typedef enum logic {
    PH_GUARD,
    PH_SHOW
  } phase_e;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_dig;
  logic [4*NUM_DIGITS-1:0] act_dig;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_guard;
  phase_e                  phase;
  logic [NUM_DIGITS-1:0]   suppressed;
  logic                    higher_sup;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_sup;
  logic [NUM_DIGITS-1:0]   en_on;
  logic [7:0]              seg_on;
  logic                    show;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   en_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CW'(GUARD_CYCLES));
    end
  endgenerate

  // Scan position: cnt walks through the slot, idx steps once per slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending always tracks the latest load; active only moves at the frame
  // boundary, and a load in that same cycle bypasses pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
      end
      if (frame_end) begin
        act_dig <= load ? digits_in : pend_dig;
        act_dp  <= load ? dp_in : pend_dp;
      end
    end
  end

  // A digit is blanked only while it and every digit above it read as a bare 0.
  always_comb begin
    suppressed = '0;
    higher_sup = 1'b1;
    if (LZ_SUPPRESS != 0) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        suppressed[k] = higher_sup && (act_dig[4*k +: 4] == 4'h0) && !act_dp[k];
        higher_sup    = suppressed[k];
      end
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    en_on   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      en_on[k] = (idx == IW'(k));
      if (idx == IW'(k)) begin
        cur_nib = act_dig[4*k +: 4];
        cur_dp  = act_dp[k];
        cur_sup = suppressed[k];
      end
    end
  end

  always_comb begin
    phase    = in_guard ? PH_GUARD : PH_SHOW;
    seg_on   = {cur_dp, hex7(cur_nib)};
    show     = (phase == PH_SHOW) && !blank_in && !cur_sup;
    seg_next = SEG_OFF;
    en_next  = EN_OFF;
    if (show) begin
      seg_next = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
      en_next  = (ACTIVE_LOW != 0) ? ~en_on : en_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segment    <= SEG_OFF;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      segment    <= seg_next;
      digit_en   <= en_next;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed display scenarios plus random
// traffic, all checked against a cycle-position reference model.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_in;
  logic [7:0]  segment;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fd = -1;

  int          pos;
  logic [15:0] m_pend_d;
  logic [15:0] m_act_d;
  logic [3:0]  m_pend_dp;
  logic [3:0]  m_act_dp;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_en;
  logic        exp_fd;

  logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .ACTIVE_LOW(1), .LZ_SUPPRESS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .segment(segment), .digit_en(digit_en), .frame_done(frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Highest digit still shown: the top digit carrying a nonzero nibble or a dp.
  function automatic int highestSig(input logic [15:0] d, input logic [3:0] dp);
    int h = 0;
    for (int k = 0; k < ND; k++)
      if (d[4*k +: 4] != 4'h0 || dp[k]) h = k;
    return h;
  endfunction

  // Reference: position since reset decides slot/offset; outputs describe this cycle.
  task automatic modelStep();
    int slot, off;
    logic [7:0] raw;
    if (!rst_n) begin
      pos = 0;
      m_pend_d = '0; m_pend_dp = '0; m_act_d = '0; m_act_dp = '0;
      exp_seg = 8'hFF; exp_en = 4'hF; exp_fd = 1'b0;
    end else begin
      slot = (pos / RD) % ND;
      off  = pos % RD;
      exp_seg = 8'hFF;
      exp_en  = 4'hF;
      if (off >= GC && !blank_in && slot <= highestSig(m_act_d, m_act_dp)) begin
        raw     = {m_act_dp[slot], dec_tbl[m_act_d[4*slot +: 4]]};
        exp_seg = ~raw;
        exp_en  = ~(4'b0001 << slot);
      end
      exp_fd = ((pos % FRAME) == FRAME - 1);
      if ((pos % FRAME) == FRAME - 1) begin
        m_act_d  = load ? digits_in : m_pend_d;
        m_act_dp = load ? dp_in : m_pend_dp;
      end
      if (load) begin
        m_pend_d  = digits_in;
        m_pend_dp = dp_in;
      end
      pos++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                               input logic [3:0] dp, input logic blk);
    rst_n = r; load = ld; digits_in = d; dp_in = dp; blank_in = blk;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    checkOutput("segment", segment, exp_seg);
    checkOutput("digit_en", digit_en, exp_en);
    checkOutput("frame_done", frame_done, exp_fd);
    if (!r) last_fd = -1;
    else if (frame_done === 1'b1) begin
      if (last_fd >= 0) checkOutput("fd_period", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic waitFrame();
    logic seen = 1'b0;
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      idle(1);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checkOutput("frame_seen", seen, 1);
  endtask

  // Starts right after a frame_done output; samples one shown cycle per slot.
  task automatic checkFrame(input string tag, input logic [31:0] segs, input logic [15:0] ens);
    for (int s = 0; s < ND; s++)
      for (int c = 0; c < RD; c++) begin
        idle(1);
        if (c < GC) checkOutput({tag, "_guard"}, digit_en, 4'hF);
        if (c == 4) begin
          checkOutput({tag, "_seg"}, segment, segs[8*s +: 8]);
          checkOutput({tag, "_en"}, digit_en, ens[4*s +: 4]);
        end
      end
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdp;
    logic        rblk;
    int          nz;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    checkOutput("rst_seg", segment, 8'hFF);
    checkOutput("rst_en", digit_en, 4'hF);
    checkOutput("rst_fd", frame_done, 0);
    idle(1);
    checkOutput("rel_c1_en", digit_en, 4'hF);
    idle(1);
    checkOutput("rel_c2_en", digit_en, 4'hF);
    idle(1);
    checkOutput("first_digit_en", digit_en, 4'b1110);

    applyStimulus(1'b1, 1'b1, 16'h12AF, 4'h0, 1'b0);
    waitFrame();
    checkFrame("dec", {8'hF9, 8'hA4, 8'h88, 8'h8E}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    applyStimulus(1'b1, 1'b1, 16'h0007, 4'h0, 1'b0);
    waitFrame();
    checkFrame("lz7", {8'hFF, 8'hFF, 8'hFF, 8'hF8}, {4'hF, 4'hF, 4'hF, 4'b1110});
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0, 1'b0);
    waitFrame();
    checkFrame("lz0", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'b1110});
    applyStimulus(1'b1, 1'b1, 16'h0007, 4'b0100, 1'b0);
    waitFrame();
    checkFrame("lzdp", {8'hFF, 8'h40, 8'hC0, 8'hF8}, {4'hF, 4'b1011, 4'b1101, 4'b1110});

    // Mid-frame load at slot 1, cycle 3: old contents finish the frame.
    idle(RD + 3);
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    waitFrame();
    checkFrame("tear", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    // Load exactly on the boundary cycle, with a second load just before it.
    idle(FRAME - 2);
    applyStimulus(1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hC0DE, 4'h0, 1'b0);
    checkOutput("bnd_fd", frame_done, 1);
    checkFrame("bnd", {8'hC6, 8'hC0, 8'hA1, 8'h86}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    idle(5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom), 4'h0, 1'b1);
      checkOutput("blank_en", digit_en, 4'hF);
    end
    waitFrame();
    checkFrame("post_blank", {8'hC6, 8'hC0, 8'hA1, 8'h86}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    idle(2 * RD + 4);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    checkOutput("mid_rst_en", digit_en, 4'hF);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(GC + 1);
    checkOutput("mid_rst_en0", digit_en, 4'b1110);
    checkOutput("mid_rst_seg0", segment, 8'hC0);

    rblk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nz  = $urandom_range(0, 4);
      rd  = (nz == 0) ? 16'h0 : (16'($urandom) & 16'(32'hFFFF >> (16 - 4 * nz)));
      rdp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 24) == 0) rblk = ~rblk;
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0, rd, rdp, rblk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for an N-digit seven-segment display. It builds on the single-digit combinational hex decoder by adding a refresh scan counter, per-digit decimal points, leading-zero suppression, inter-digit ghost blanking and tear-free frame-synchronous loading. It sits between register or counter logic that produces packed hex nibbles and the board's segment and digit-select pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be > GUARD_CYCLES and ≥ 2.
- GUARD_CYCLES, 2: cycles at the start of each slot with every digit disabled, to suppress ghosting.
- ACTIVE_LOW, 1: 1 means `segment` and `digit_en` are active-low (common anode); 0 means active-high.
- LZ_SUPPRESS, 1: 1 enables leading-zero blanking.
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- load  in  1  capture `digits_in`/`dp_in` into the pending register
- digits_in  in  4*NUM_DIGITS  packed hex nibbles; digit 0 = bits [3:0] = rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit
- blank_in  in  1  force all digits off; scan keeps running
- segment  out  8  {dp,g,f,e,d,c,b,a}, registered
- digit_en  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW), registered
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot

## Operation
- Decode, in active-high gfedcba form before polarity:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - dp adds bit 7.
- Registers:
  - slot counter `cnt` (0..REFRESH_DIV-1)
  - digit index `idx` (0..NUM_DIGITS-1)
  - pending {digits,dp}
  - active {digits,dp}
- Scan sequence:
  - `cnt` increments every cycle.
  - At REFRESH_DIV-1, `cnt` wraps to 0 and `idx` advances.
  - `idx` wraps from NUM_DIGITS-1 to 0 (the frame boundary).
- Load:
  - `load`=1 writes pending in that cycle.
  - On the frame-boundary cycle, active <= (load ? inputs : pending), so a simultaneous load is applied immediately.
  - Active never changes mid-frame, so a frame is never torn.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit k is suppressed when its nibble is 0, its dp is 0, and every higher digit is also suppressed.
  - Digit 0 is never suppressed.
- Output for the current slot:
  - Digit is off when cnt < GUARD_CYCLES, blank_in=1, or the digit is suppressed.
  - Digit off: digit_en all inactive and segment all inactive.
  - Otherwise: digit_en[idx] active and segment = decode(active nibble idx) | dp.
  - ACTIVE_LOW=1 inverts both buses.
- State machine: implicit in (`idx`, `cnt`). Each slot passes through GUARD and then SHOW; there is no other state.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - `cnt`=0, `idx`=0; pending and active cleared to 0.
  - segment = all inactive (8'hFF when ACTIVE_LOW=1, 8'h00 otherwise); digit_en all inactive; frame_done=0.
  - Reset asserted mid-frame aborts the scan; the next frame starts from digit 0.
- Outputs are registered and reflect the `cnt`/`idx`/blank_in values from the previous cycle. Latency is 1 cycle.
- After reset release, digit 0 becomes active on output cycle GUARD_CYCLES+1.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. frame_done pulses exactly once per frame.
- Load latency depends on when `load` arrives:
  - Mid-frame: appears at the start of the next frame.
  - On the boundary cycle: appears in the frame that begins then.
  - On consecutive cycles: last value wins.
- blank_in takes effect 1 cycle after it is sampled and does not disturb `cnt`, `idx` or the registers.
- GUARD_CYCLES=0 gives no dead time.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, ACTIVE_LOW=1, LZ_SUPPRESS=1.

1. **Reset**: rst_n=0 for 3 cycles, then release -> segment=8'hFF, digit_en=4'hF, frame_done=0. First digit_en=4'b1110 appears on output cycle 3 after release.
2. **Decode/scan**: load 16'h12AF, dp=0, wait one boundary ->
   - slot0: digit_en=1110, segment=8'h8E
   - slot1: digit_en=1101, segment=8'h88
   - slot2: digit_en=1011, segment=8'hA4
   - slot3: digit_en=0111, segment=8'hF9
3. **LZ/dp**:
   - 16'h0007 -> only digit 0 shown, segment 8'hF8; digits 1–3 stay off.
   - 16'h0000 -> digit 0 shows 8'hC0.
   - 16'h0007 with dp_in=4'b0100 -> digit 2 shows 8'h40 and digit 1 shows 8'hC0.
4. **Tear-free load**:
   - Load 16'h1111 at slot 1, cycle 3 -> slots 1–3 keep the old values; new values appear from the next slot 0.
   - Load asserted on the boundary cycle -> new value appears in slot 0 immediately.
5. **Guard/frame_done**: over 64 cycles ->
   - frame_done high exactly twice, 32 cycles apart, on the last cycle of slot 3.
   - digit_en=4'hF for exactly 2 cycles at each slot start.
6. **Blank and mid-frame reset**:
   - blank_in=1 for 10 cycles -> digit_en=4'hF during that window, and the scan position is unchanged afterwards.
   - rst_n=0 during slot 2 -> outputs inactive; the scan restarts at digit 0 with cleared contents.
